mem_bus_adapter: RTL and testbench
==================================

# mem_bus_adapter

Data-memory adapter between the CPU's MEM stage and a 32-bit external memory bus. It accepts one load/store request at a time, checks its alignment, and splits it into one or two 32-bit bus beats with byte strobes. For loads it sign- or zero-extends the returned data to WIDTH bits. It then returns a single completion response to the MEM stage.

## Interface
- WIDTH, 64, address and register data width; only 64 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  adapter can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  WIDTH  byte address.
- req_wdata  input  WIDTH  store data, right-aligned.
- req_control  input  3  funct3 size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- resp_valid  output  1  one-cycle completion pulse.
- resp_error  output  1  qualifies resp_valid; 1 = misaligned or illegal request.
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
- bus_valid  output  1  beat request.
- bus_ready  input  1  memory accepts or completes the beat.
- bus_we  output  1  beat is a write.
- bus_addr  output  WIDTH  word-aligned beat address, bits [1:0] always 00.
- bus_wdata  output  32  write lanes.
- bus_wstrb  output  4  byte-lane enables; 0000 on reads.
- bus_rdata  input  32  read data, valid in the cycle where bus_valid && bus_ready.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- Accept: req_valid && req_ready captures write, addr, wdata and control into registers.
- Error check on accept: illegal control (111), or stores using 100, 101 or 110, or size-misaligned address (H: addr[0]; W/WU: addr[1:0]; D: addr[2:0] nonzero).
  - On error: IDLE→RESP with resp_error=1, resp_rdata=0, and no bus activity.
- Valid request: IDLE→BEAT0.
- Byte/half/word requests use one beat.
  - bus_addr = {addr[WIDTH-1:2],2'b00}.
  - Store data is replicated across lanes, e.g. B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}.
  - bus_wstrb = B: 0001<<addr[1:0]; H: 0011<<addr[1:0]; W: 1111.
- Double requests use two beats:
  - BEAT0 carries the low word at addr, with wstrb 1111 for stores.
  - BEAT1 carries the high word at addr+4.
- BEAT0 completion (bus_valid && bus_ready): go to BEAT1 for D, otherwise RESP. BEAT1 completion: go to RESP.
- Read data is captured on beat completion.
- Load extraction:
  - Selected lane = bus_rdata >> (8*addr[1:0]).
  - B/H/W sign-extend to WIDTH.
  - BU/HU/WU zero-extend to WIDTH.
  - D = {beat1_rdata, beat0_rdata}.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Stores respond with resp_rdata=0 and resp_error=0.
- bus_valid is high throughout BEAT0/BEAT1. bus_addr, bus_we, bus_wdata and bus_wstrb hold stable while bus_valid && !bus_ready.
- A req_valid during BEAT0/BEAT1/RESP is not accepted (req_ready=0); the requester holds it.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
- Asserting rst mid-transaction forces IDLE immediately (asynchronous). bus_valid drops with it, and the captured request is discarded with no response.
- Zero-wait single beat:
  - Request accepted at edge T.
  - bus_valid high in cycle T..T+1.
  - resp_valid high in cycle T+1..T+2.
  - Next request accepted at edge T+2 at the earliest.
- Zero-wait double beat: resp_valid appears one cycle later than a single beat.
- Error response: resp_valid high in the cycle after accept.
- Each bus wait cycle (bus_ready=0) adds exactly one cycle of latency.
- All outputs are registered or decoded from state only; there are no combinational paths from req_* or bus_* inputs to outputs.

## Test plan
- LB at addr 0x1003, bus_rdata=0x80FF_FFFF, zero-wait -> one read beat at bus_addr 0x1000; resp_rdata=0xFFFF_FFFF_FFFF_FF80; resp_valid two cycles after accept.
- LHU at 0x2002, bus_rdata=0xBEEF_1234 -> resp_rdata=0x0000_0000_0000_BEEF, resp_error=0.
- SH at 0x3002, wdata=0x1122_3344_5566_7788 -> single beat with bus_we=1, bus_wstrb=1100, bus_wdata=0x7788_7788; resp_rdata=0.
- LD at 0x4000, beats return 0x89AB_CDEF then 0x0123_4567, with bus_ready held low 2 cycles on beat 0 -> bus_addr 0x4000 then 0x4004; resp_rdata=0x0123_4567_89AB_CDEF; resp_valid 5 cycles after accept.
- LW at 0x5002 and control=111 at 0x5000 -> each gives resp_error=1 one cycle after accept; bus_valid never asserts.
- SD accepted, rst pulled low while BEAT0 is stalled -> bus_valid=0 immediately; no resp_valid; req_ready=1 after rst releases; a new LW then completes normally.

Source files
------------

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter
//
// Data-memory adapter between the CPU MEM stage and a 32-bit external bus.
// It takes one load/store request at a time and checks its alignment and
// size code. It then issues one or two word-aligned bus beats with byte
// strobes. Load data is sign- or zero-extended. The MEM stage receives a
// single one-cycle completion pulse.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   req_control         funct3 size code (B,H,W,D,BU,HU,WU,illegal)
//   resp_valid          one-cycle completion pulse
//   resp_error          misaligned/illegal request, qualifies resp_valid
//   resp_rdata          extended load data, 0 for stores and errors
//   bus_valid/ready     beat handshake
//   bus_we              beat is a write
//   bus_addr            word-aligned beat address
//   bus_wdata/wstrb     write lanes and byte enables (strobes 0 on reads)
//   bus_rdata           read data, valid when bus_valid && bus_ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// BEAT0 | first (or only) bus beat in flight
// BEAT1 | high word of a doubleword at addr+4
// RESP  | one-cycle completion pulse to the MEM stage

module mem_bus_adapter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_control,
  output logic             resp_valid,
  output logic             resp_error,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             write_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  logic [31:0]      lo_q;
  logic [WIDTH-1:0] rdata_q;

  logic             accept;
  logic             misaligned;
  logic             req_err;
  logic             is_double;
  logic             in_beat;
  logic             beat_done;
  logic [31:0]      lane;
  logic [WIDTH-1:0] lane_ext;
  logic [WIDTH-1:0] beat_base;
  logic [WIDTH-1:0] beat_ofs;

  assign accept    = req_valid && (state_q == IDLE);
  assign is_double = (ctrl_q == 3'b011);
  assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);
  assign beat_done = in_beat && bus_ready;

  // Alignment is judged by the size bits alone; BU/HU/WU share rules with B/H/W.
  always_comb begin
    misaligned = 1'b0;
    case (req_control[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  // Unsigned size codes have no store meaning.
  assign req_err = (req_control == 3'b111) || (req_write && req_control[2]) || misaligned;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_err ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          state_d = is_double ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture and read-data assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      ctrl_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        ctrl_q  <= req_control;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (beat_done) begin
        if (state_q == BEAT1) begin
          rdata_q <= {bus_rdata, lo_q};
        end else if (is_double) begin
          lo_q <= bus_rdata;
        end else begin
          rdata_q <= lane_ext;
        end
      end
    end
  end

  // Addressed byte/half/word moved down to bit 0 before extension.
  assign lane = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    lane_ext = '0;
    case (ctrl_q)
      3'b000:  lane_ext = {{(WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  lane_ext = {{(WIDTH-16){lane[15]}}, lane[15:0]};
      3'b010:  lane_ext = {{(WIDTH-32){lane[31]}}, lane[31:0]};
      3'b100:  lane_ext = {{(WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  lane_ext = {{(WIDTH-16){1'b0}}, lane[15:0]};
      3'b110:  lane_ext = {{(WIDTH-32){1'b0}}, lane[31:0]};
      default: lane_ext = '0;
    endcase
  end

  // The second beat of a doubleword sits at the next word.
  assign beat_base = {addr_q[WIDTH-1:2], 2'b00};
  assign beat_ofs  = {{(WIDTH-3){1'b0}}, (state_q == BEAT1), 2'b00};

  // Outputs are decoded from state and captured registers only, so every
  // bus field holds steady while a beat is stalled.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_error = (state_q == RESP) && err_q;
    resp_rdata = '0;
    bus_valid  = in_beat;
    bus_we     = in_beat && write_q;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_wstrb  = 4'b0000;

    if ((state_q == RESP) && !err_q && !write_q) begin
      resp_rdata = rdata_q;
    end

    if (in_beat) begin
      bus_addr = beat_base + beat_ofs;
    end

    if (in_beat && write_q) begin
      case (ctrl_q[1:0])
        2'b00: begin
          bus_wdata = {4{wdata_q[7:0]}};
          bus_wstrb = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          bus_wdata = {2{wdata_q[15:0]}};
          bus_wstrb = 4'b0011 << addr_q[1:0];
        end
        2'b10: begin
          bus_wdata = wdata_q[31:0];
          bus_wstrb = 4'b1111;
        end
        default: begin
          bus_wdata = (state_q == BEAT1) ? wdata_q[63:32] : wdata_q[31:0];
          bus_wstrb = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_adapter.sv
module tb_mem_bus_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_control;
  logic        resp_valid;
  logic        resp_error;
  logic [63:0] resp_rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_bus_adapter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_control(req_control),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] c);
    case (c[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic bit model_err(input logic wr, input logic [2:0] c, input logic [63:0] a);
    int n;
    n = size_of(c);
    if (c == 3'b111) return 1'b1;
    if (wr && c[2]) return 1'b1;
    return (a % 64'(n)) != 64'd0;
  endfunction

  // Bytes returned by the bus, taken n at a time from the addressed offset.
  function automatic logic [63:0] model_load(input logic [2:0] c, input logic [63:0] a,
                                             input logic [31:0] w0, input logic [31:0] w1);
    int n;
    logic [63:0] raw, msk, v;
    n = size_of(c);
    if (n == 8) return {w1, w0};
    raw = {32'd0, w0} >> (8 * int'(a[1:0]));
    msk = (64'd1 << (8 * n)) - 64'd1;
    v   = raw & msk;
    if (!c[2] && v[8*n-1]) v = v | ~msk;
    return v;
  endfunction

  // A lane is enabled when its byte address falls inside [a, a+n).
  function automatic logic [3:0] model_strb(input logic [63:0] a, input int n, input int beat);
    logic [63:0] base;
    logic [3:0]  s;
    base = (a & ~64'h3) + 64'(4 * beat);
    for (int i = 0; i < 4; i++) s[i] = ((base + 64'(i) - a) < 64'(n));
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [63:0] wd, input int n, input int beat);
    logic [31:0] w;
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (n >= 4) ? (4 * beat + i) : (i % n);
      w[8*i +: 8] = wd[8*k +: 8];
    end
    return w;
  endfunction

  // ---------------- one complete transaction ----------------
  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input string tag, input logic wr, input logic [2:0] c,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input int w0, input int w1,
                         output int lat, output logic [63:0] rdata, output logic err);
    int n, beats, bidx, waited, bus_cycles, e_lat, e_cycles, k;
    int waits[2];
    logic [31:0] rds[2];
    bit got, e_err;
    logic [63:0] e_rdata;

    n        = size_of(c);
    e_err    = model_err(wr, c, a);
    beats    = e_err ? 0 : ((n == 8) ? 2 : 1);
    e_cycles = beats + ((beats >= 1) ? w0 : 0) + ((beats == 2) ? w1 : 0);
    e_lat    = e_err ? 1 : (1 + e_cycles);
    e_rdata  = (e_err || wr) ? 64'd0 : model_load(c, a, rd0, rd1);
    waits[0] = w0; waits[1] = w1;
    rds[0]   = rd0; rds[1] = rd1;

    chk({tag, " ready_idle"}, 64'(req_ready), 64'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_control = c;
    req_addr    = a;
    req_wdata   = wd;
    bus_ready   = 1'b0;
    bus_rdata   = $urandom;
    @(posedge clk);

    lat = 0; got = 1'b0; bidx = 0; waited = 0; bus_cycles = 0;
    rdata = '0; err = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      // Requester keeps req_valid up with changing fields; none may leak in.
      req_addr    = {$urandom, $urandom};
      req_wdata   = {$urandom, $urandom};
      req_control = 3'($urandom);
      req_write   = 1'($urandom);
      chk({tag, " ready_busy"}, 64'(req_ready), 64'd0);
      if (bus_valid) begin
        k = (bidx > 1) ? 1 : bidx;
        bus_cycles++;
        chk({tag, " bus_addr"}, bus_addr, (a & ~64'h3) + 64'(4 * k));
        chk({tag, " bus_we"}, 64'(bus_we), 64'(wr));
        chk({tag, " bus_wstrb"}, 64'(bus_wstrb), wr ? 64'(model_strb(a, n, k)) : 64'd0);
        if (wr) chk({tag, " bus_wdata"}, 64'(bus_wdata), 64'(model_wdata(wd, n, k)));
        bus_rdata = $urandom;
        if (waited < waits[k]) begin
          bus_ready = 1'b0;
          waited++;
        end else begin
          bus_ready = 1'b1;
          bus_rdata = rds[k];
          bidx++;
          waited = 0;
        end
      end else begin
        bus_ready = 1'b0;
      end
      if (resp_valid) begin
        got       = 1'b1;
        rdata     = resp_rdata;
        err       = resp_error;
        req_valid = 1'b0;
        bus_ready = 1'b0;
      end
    end
    req_valid = 1'b0;
    bus_ready = 1'b0;

    chk({tag, " resp_seen"}, 64'(got), 64'd1);
    chk({tag, " resp_error"}, 64'(err), 64'(e_err));
    chk({tag, " resp_rdata"}, rdata, e_rdata);
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " bus_cycles"}, 64'(bus_cycles), 64'(e_cycles));

    @(negedge clk);
    chk({tag, " resp_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, " ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] rd;
    logic er;
    logic [2:0] c;
    logic wr;
    logic [63:0] a;
    int n;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_control = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);

    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst resp_error", 64'(resp_error), 64'd0);
    chk("rst resp_rdata", resp_rdata, 64'd0);
    chk("rst bus_valid", 64'(bus_valid), 64'd0);
    chk("rst bus_we", 64'(bus_we), 64'd0);
    chk("rst bus_addr", bus_addr, 64'd0);
    chk("rst bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rst bus_wstrb", 64'(bus_wstrb), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn("lb", 1'b0, 3'b000, 64'h1003, 64'd0, 32'h80FF_FFFF, 32'd0, 0, 0, lat, rd, er);
    chk("lb value", rd, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb lat", 64'(lat), 64'd2);

    run_txn("lhu", 1'b0, 3'b101, 64'h2002, 64'd0, 32'hBEEF_1234, 32'd0, 0, 0, lat, rd, er);
    chk("lhu value", rd, 64'h0000_0000_0000_BEEF);
    chk("lhu err", 64'(er), 64'd0);

    run_txn("sh", 1'b1, 3'b001, 64'h3002, 64'h1122_3344_5566_7788, 32'd0, 32'd0, 0, 0, lat, rd, er);
    chk("sh value", rd, 64'd0);

    run_txn("ld", 1'b0, 3'b011, 64'h4000, 64'd0, 32'h89AB_CDEF, 32'h0123_4567, 2, 0, lat, rd, er);
    chk("ld value", rd, 64'h0123_4567_89AB_CDEF);
    chk("ld lat", 64'(lat), 64'd5);

    run_txn("lw_mis", 1'b0, 3'b010, 64'h5002, 64'd0, 32'h1111_1111, 32'd0, 0, 0, lat, rd, er);
    chk("lw_mis err", 64'(er), 64'd1);
    chk("lw_mis lat", 64'(lat), 64'd1);

    run_txn("illegal", 1'b0, 3'b111, 64'h5000, 64'd0, 32'h2222_2222, 32'd0, 0, 0, lat, rd, er);
    chk("illegal err", 64'(er), 64'd1);

    run_txn("sd", 1'b1, 3'b011, 64'h8008, 64'hCAFE_F00D_DEAD_BEEF, 32'd0, 32'd0, 1, 2, lat, rd, er);
    chk("sd lat", 64'(lat), 64'd6);

    // Reset while BEAT0 of a doubleword store is stalled
    req_valid = 1'b1; req_write = 1'b1; req_control = 3'b011;
    req_addr = 64'h6000; req_wdata = 64'h0102_0304_0506_0708; bus_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sd_rst beat0", 64'(bus_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("sd_rst bus_valid", 64'(bus_valid), 64'd0);
    chk("sd_rst req_ready", 64'(req_ready), 64'd1);
    chk("sd_rst bus_wstrb", 64'(bus_wstrb), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("sd_rst no_resp", 64'(resp_valid), 64'd0);
      chk("sd_rst idle_bus", 64'(bus_valid), 64'd0);
    end
    run_txn("lw_after", 1'b0, 3'b010, 64'h7004, 64'd0, 32'h8000_0001, 32'd0, 0, 0, lat, rd, er);
    chk("lw_after value", rd, 64'hFFFF_FFFF_8000_0001);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      c  = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      n  = size_of(c);
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(n) - 64'd1);
      run_txn($sformatf("rnd%0d", t), wr, c, a, {$urandom, $urandom}, $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), lat, rd, er);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
